// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART command-frame decoder.
// A frame is SOF, ADDR, DATA_LO, DATA_HI, CHK where CHK = ADDR ^ DATA_LO ^ DATA_HI.
package uart_frame_pkg;

    // Frame assembly position; one state per byte slot of the frame.
    typedef enum logic [2:0] {
        S_SOF  = 3'd0,
        S_ADDR = 3'd1,
        S_DLO  = 3'd2,
        S_DHI  = 3'd3,
        S_CHK  = 3'd4
    } frame_state_e;

    localparam int         FRAME_LEN   = 5;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Checksum byte expected at the end of a frame.
    function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        return addr ^ lo ^ hi;
    endfunction

endpackage

// File: rtl/uart_frame_decoder.sv
// UART command-frame decoder.
// Assembles 5-byte frames from the UART receiver byte strobe, verifies the
// XOR checksum and presents {addr, data} on a one-entry valid/ready slot.
// Optional inter-byte timeout is built only when UART_FRAME_TIMEOUT_EN is
// defined; otherwise o_Err_Timeout is tied low and no counter exists.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
    parameter int         CLKS_PER_BIT = 5208,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Cmd_Valid,
    input  logic        i_Cmd_Ready,
    output logic [7:0]  o_Cmd_Addr,
    output logic [15:0] o_Cmd_Data,
    output logic        o_Err_Chk,
    output logic        o_Err_Ovf,
    output logic        o_Err_Timeout
);

    // Bit period and timeout length must both be positive to give a
    // meaningful timeout window.
    if (CLKS_PER_BIT < 1 || TIMEOUT_BITS < 1) begin : g_bad_cfg
        $error("uart_frame_decoder: CLKS_PER_BIT and TIMEOUT_BITS must be >= 1");
    end

    frame_state_e state_q, state_d;

    logic [7:0]  addr_q, addr_d;
    logic [7:0]  lo_q,   lo_d;
    logic [7:0]  hi_q,   hi_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_addr_q,  cmd_addr_d;
    logic [15:0] cmd_data_q,  cmd_data_d;

    logic        err_chk_q, err_chk_d;
    logic        err_ovf_q, err_ovf_d;
    logic        err_to_q,  err_to_d;

    logic        frame_good;
    logic        frame_bad;
    logic        timeout_hit;
    logic        accept;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TO_LIMIT = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
    localparam logic [TO_W-1:0] TO_TERM = TO_W'(TO_LIMIT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Inter-byte gap counter: idle while hunting for SOF, restarted by every
    // byte; a byte arriving on the terminal count takes priority.
    always_comb begin
        to_cnt_d    = to_cnt_q + TO_ONE;
        timeout_hit = 1'b0;
        if (i_Rx_DV || state_q == S_SOF) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_TERM) begin
            to_cnt_d    = '0;
            timeout_hit = 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame FSM next state and byte capture; SOF bytes mid-frame are data.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (timeout_hit) begin
            state_d = S_SOF;
        end else if (i_Rx_DV) begin
            case (state_q)
                S_SOF: begin
                    if (i_Rx_Byte == SOF_BYTE) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_d  = i_Rx_Byte;
                    state_d = S_DLO;
                end
                S_DLO: begin
                    lo_d    = i_Rx_Byte;
                    state_d = S_DHI;
                end
                S_DHI: begin
                    hi_d    = i_Rx_Byte;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (i_Rx_Byte == frame_chk(addr_q, lo_q, hi_q)) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_d = S_SOF;
                end
                default: begin
                    state_d = S_SOF;
                end
            endcase
        end
    end

    // Output slot: a good frame loads when the slot is free or being drained
    // this cycle, otherwise it is dropped and flagged as an overflow.
    always_comb begin
        accept      = cmd_valid_q & i_Cmd_Ready;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_ovf_d   = 1'b0;
        if (accept) begin
            cmd_valid_d = 1'b0;
        end
        if (frame_good) begin
            if (!cmd_valid_q || accept) begin
                cmd_valid_d = 1'b1;
                cmd_addr_d  = addr_q;
                cmd_data_d  = {hi_q, lo_q};
            end else begin
                err_ovf_d = 1'b1;
            end
        end
    end

    // Error pulses; checksum/overflow need a byte, timeout needs its absence,
    // so at most one is ever raised per cycle.
    always_comb begin
        err_chk_d = frame_bad;
        err_to_d  = timeout_hit;
    end

    // FSM state register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame assembly, output slot and error pulse registers.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            addr_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            err_chk_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_chk_q   <= err_chk_d;
            err_ovf_q   <= err_ovf_d;
            err_to_q    <= err_to_d;
        end
    end

    assign o_Cmd_Valid   = cmd_valid_q;
    assign o_Cmd_Addr    = cmd_addr_q;
    assign o_Cmd_Data    = cmd_data_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Ovf     = err_ovf_q;
    assign o_Err_Timeout = err_to_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_uart_frame_decoder;

    logic        clk;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        err_chk;
    logic        err_ovf;
    logic        err_to;

    int n_cmp = 0;
    int n_mis = 0;

    uart_frame_decoder #(
        .SOF_BYTE    (8'hA5),
        .CLKS_PER_BIT(4),
        .TIMEOUT_BITS(5)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .o_Cmd_Valid  (cmd_valid),
        .i_Cmd_Ready  (cmd_ready),
        .o_Cmd_Addr   (cmd_addr),
        .o_Cmd_Data   (cmd_data),
        .o_Err_Chk    (err_chk),
        .o_Err_Ovf    (err_ovf),
        .o_Err_Timeout(err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; strobes one byte for one cycle.
    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
        send(8'hA5);
        send(a);
        send(lo);
        send(hi);
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] a, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        chk({tag, "_addr"},  32'(cmd_addr),  32'(a));
        chk({tag, "_data"},  32'(cmd_data),  32'(d));
    endtask

    task automatic check_errs(input string tag, input logic c, input logic o, input logic t);
        chk({tag, "_errchk"}, 32'(err_chk), 32'(c));
        chk({tag, "_errovf"}, 32'(err_ovf), 32'(o));
        chk({tag, "_errto"},  32'(err_to),  32'(t));
    endtask

    // Hard stop if the bench itself loses its way.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rx_dv     = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        idle(3);

        // Reset state
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_addr",  32'(cmd_addr),  32'd0);
        chk("rst_data",  32'(cmd_data),  32'd0);
        check_errs("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1);

        // Basic frame, consumer always ready
        cmd_ready = 1'b1;
        send_hdr(8'h12, 8'h34, 8'h56);
        chk("f1_early_valid", 32'(cmd_valid), 32'd0);
        send(8'h70);
        check_cmd("f1", 8'h12, 16'h5634);
        check_errs("f1", 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("f1_cleared", 32'(cmd_valid), 32'd0);

        // Leading junk ignored while hunting SOF
        send(8'h00);
        send(8'hFF);
        send_hdr(8'h01, 8'h02, 8'h03);
        send(8'h00);
        check_cmd("junk", 8'h01, 16'h0302);
        idle(1);
        chk("junk_cleared", 32'(cmd_valid), 32'd0);

        // Checksum error then recovery
        send_hdr(8'h12, 8'h34, 8'h56);
        send(8'h71);
        check_errs("bad", 1'b1, 1'b0, 1'b0);
        chk("bad_valid", 32'(cmd_valid), 32'd0);
        idle(1);
        chk("bad_pulse_end", 32'(err_chk), 32'd0);
        send_hdr(8'hAB, 8'hCD, 8'hEF);
        send(8'h89);
        check_cmd("recov", 8'hAB, 16'hEFCD);
        idle(1);

        // Slot full: second good frame dropped
        cmd_ready = 1'b0;
        send_hdr(8'h11, 8'h22, 8'h33);
        send(8'h00);
        check_cmd("ovf1", 8'h11, 16'h3322);
        send_hdr(8'h44, 8'h55, 8'h66);
        check_cmd("ovf_hold", 8'h11, 16'h3322);
        send(8'h77);
        check_cmd("ovf2", 8'h11, 16'h3322);
        check_errs("ovf2", 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("ovf_pulse_end", 32'(err_ovf), 32'd0);

        // Slot drained in the same cycle as the CHK byte: reload, no overflow
        send_hdr(8'h44, 8'h55, 8'h66);
        cmd_ready = 1'b1;
        send(8'h77);
        cmd_ready = 1'b0;
        check_cmd("swap", 8'h44, 16'h6655);
        check_errs("swap", 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("swap_hold", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        idle(1);
        chk("swap_drain", 32'(cmd_valid), 32'd0);

        // Reset mid-frame with a full slot
        cmd_ready = 1'b0;
        send_hdr(8'h01, 8'h02, 8'h03);
        send(8'h00);
        chk("prerst_valid", 32'(cmd_valid), 32'd1);
        send(8'hA5);
        send(8'h12);
        send(8'h34);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(cmd_valid), 32'd0);
        chk("arst_addr",  32'(cmd_addr),  32'd0);
        chk("arst_data",  32'(cmd_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        cmd_ready = 1'b1;
        send(8'h56);
        send(8'h70);
        chk("post_rst_valid", 32'(cmd_valid), 32'd0);
        check_errs("post_rst", 1'b0, 1'b0, 1'b0);
        send_hdr(8'h12, 8'h34, 8'h56);
        send(8'h70);
        check_cmd("post_rst", 8'h12, 16'h5634);
        idle(1);

`ifdef UART_FRAME_TIMEOUT_EN
        // Gap of 20 clocks mid-frame times out (terminal count 19)
        send(8'hA5);
        send(8'h12);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk("to_quiet", 32'(err_to), 32'd0);
        end
        @(negedge clk);
        check_errs("to_fire", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("to_pulse_end", 32'(err_to), 32'd0);
        send_hdr(8'h21, 8'h43, 8'h65);
        send(8'h07);
        check_cmd("to_resync", 8'h21, 16'h6543);
        idle(1);

        // Byte on the terminal count wins
        send(8'hA5);
        send(8'h12);
        idle(19);
        send(8'h34);
        chk("to_race", 32'(err_to), 32'd0);
        send(8'h56);
        send(8'h70);
        check_cmd("to_race", 8'h12, 16'h5634);
        chk("to_race_after", 32'(err_to), 32'd0);
        idle(1);
`else
        // Without the timeout a long gap leaves the frame pending
        send(8'hA5);
        send(8'h12);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 10 == 9) chk("nto_quiet", 32'(err_to), 32'd0);
        end
        send(8'h34);
        send(8'h56);
        send(8'h70);
        check_cmd("nto", 8'h12, 16'h5634);
        idle(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
